// File: rtl/wave_sequencer.sv
// wave_sequencer: 4-slot playlist controller driving wave select, generator enable and status LED.
// Optional one-shot mode (stop after slot 3 instead of wrapping) is enabled by defining WAVE_SEQ_ONESHOT_EN.
module wave_sequencer #(
    parameter int DWELL_W       = 16,
    parameter int DEFAULT_DWELL = 1000,
    parameter int GAP_TICKS     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stop,
    input  logic               step,
    input  logic               tick,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [1:0]         wr_sel,
    input  logic [DWELL_W-1:0] wr_dwell,
    output logic [1:0]         sel,
    output logic               gen_ena,
    output logic [2:0]         rgb,
    output logic [1:0]         slot,
    output logic               busy
`ifdef WAVE_SEQ_ONESHOT_EN
    ,
    input  logic               oneshot,
    output logic               done
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_ERROR} state_t;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [DWELL_W-1:0] DWELL_RST = DWELL_W'(DEFAULT_DWELL);
    state_t             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]         cur_sel_q, cur_sel_d;
    logic [DWELL_W-1:0] cur_dwell_q, cur_dwell_d;
    logic               done_q, done_d;
    logic [1:0]         pl_sel_q [4];
    logic [DWELL_W-1:0] pl_dwell_q [4];
    logic [1:0]         nxt_slot;
    logic               adv, expire, last_stop;
    function automatic logic [2:0] rgb_of(input logic [1:0] s);
        return (s == 2'd0) ? 3'b000 : (s == 2'd1) ? 3'b110 : (s == 2'd2) ? 3'b101 : 3'b011;
    endfunction
`ifdef WAVE_SEQ_ONESHOT_EN
    assign last_stop = oneshot && slot_q == 2'd3;
    assign done      = done_q;
`else
    assign last_stop = 1'b0;
`endif
    assign nxt_slot = slot_q + 2'd1;
    // Playlist storage; writes land at any time, the running slot uses its latched copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pl_sel_q[i]   <= (i == 3) ? 2'd0 : 2'(i + 1);
                pl_dwell_q[i] <= DWELL_RST;
            end
        end else if (wr_en) begin
            pl_sel_q[wr_addr]   <= wr_sel;
            pl_dwell_q[wr_addr] <= wr_dwell;
        end
    end
    // Sequencer state, counters and the latched settings of the active slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            dwell_cnt_q <= '0;
            gap_cnt_q   <= '0;
            cur_sel_q   <= 2'd0;
            cur_dwell_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            dwell_cnt_q <= dwell_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cur_sel_q   <= cur_sel_d;
            cur_dwell_q <= cur_dwell_d;
            done_q      <= done_d;
        end
    end
    // Next state: start_stop beats step beats tick; advancing always re-latches the slot settings.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        dwell_cnt_d = dwell_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        cur_sel_d   = cur_sel_q;
        cur_dwell_d = cur_dwell_q;
        done_d      = 1'b0;
        adv         = 1'b0;
        expire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_stop) begin
                    state_d     = S_RUN;
                    dwell_cnt_d = '0;
                    gap_cnt_d   = '0;
                    cur_sel_d   = pl_sel_q[slot_q];
                    cur_dwell_d = pl_dwell_q[slot_q];
                end else if (step) begin
                    slot_d = nxt_slot;
                end
            end
            S_RUN: begin
                if (start_stop) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    adv = 1'b1;
                end else if (cur_dwell_q == '0) begin
                    expire = 1'b1;
                end else if (tick) begin
                    if (dwell_cnt_q == cur_dwell_q - DWELL_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            expire = 1'b1;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (start_stop) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    adv = 1'b1;
                end else if (tick) begin
                    if (gap_cnt_q == GAP_LAST) expire = 1'b1;
                    else gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
        if (adv || expire) begin
            state_d     = S_RUN;
            slot_d      = nxt_slot;
            dwell_cnt_d = '0;
            gap_cnt_d   = '0;
            cur_sel_d   = pl_sel_q[nxt_slot];
            cur_dwell_d = pl_dwell_q[nxt_slot];
        end
        if (expire && last_stop) begin
            state_d = S_IDLE;
            slot_d  = 2'd0;
            done_d  = 1'b1;
        end
    end
    // Outputs decode from the state and the latched settings of the active slot.
    always_comb begin
        sel     = (state_q == S_RUN) ? cur_sel_q : 2'd0;
        gen_ena = (state_q == S_RUN) && (cur_sel_q != 2'd0);
        rgb     = (state_q == S_RUN) ? rgb_of(cur_sel_q) : (state_q == S_ERROR) ? 3'b100 : 3'b000;
        slot    = slot_q;
        busy    = (state_q == S_RUN) || (state_q == S_GAP);
    end
endmodule
